// File: rtl/bip_pkg.sv
// Shared widths, control-word encodings and the signed-overflow rule for the
// BIP datapath.
package bip_pkg;

  localparam int unsigned NB_DATA          = 16;
  localparam int unsigned NB_OPERAND       = 11;
  localparam int unsigned N_DATA_ADDR      = 1024;
  localparam int unsigned LOG2_N_DATA_ADDR = 10;
  localparam int unsigned NB_SEL_A         = 2;

  typedef enum logic [NB_SEL_A-1:0] {
    SEL_A_RAM  = 2'b00,
    SEL_A_IMM  = 2'b01,
    SEL_A_ALU  = 2'b10,
    SEL_A_HOLD = 2'b11
  } sel_a_e;

  typedef enum logic {
    OP_SUB = 1'b0,
    OP_ADD = 1'b1
  } op_e;

  // Overflow from operand and result sign bits; for subtraction B is the subtrahend.
  function automatic logic signed_ovf(input logic is_add, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    logic ovf;
    if (is_add) ovf = (a_msb == b_msb) && (r_msb != a_msb);
    else        ovf = (a_msb != b_msb) && (r_msb != a_msb);
    return ovf;
  endfunction

endpackage

// File: rtl/bip_data_ram.sv
// Data RAM: one synchronous write port, asynchronous execute and debug reads.
// Reads of the location being written return the pre-edge contents.
module bip_data_ram
  import bip_pkg::*;
(
  input  logic                        i_clock,
  input  logic                        wr_en,
  input  logic [LOG2_N_DATA_ADDR-1:0] wr_addr,
  input  logic [NB_DATA-1:0]          wr_data,
  input  logic [LOG2_N_DATA_ADDR-1:0] rd_addr,
  output logic [NB_DATA-1:0]          rd_data,
  input  logic [LOG2_N_DATA_ADDR-1:0] dbg_addr,
  output logic [NB_DATA-1:0]          dbg_data
);

  logic [NB_DATA-1:0] mem [N_DATA_ADDR];

  always_ff @(posedge i_clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data  = mem[rd_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/bip_datapath.sv
// BIP datapath: accumulator, data RAM and signed add/sub ALU executing one
// control word per cycle from the BIP control unit.
module bip_datapath
  import bip_pkg::*;
(
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_valid,
  input  logic [NB_SEL_A-1:0]         i_sel_a,
  input  logic                        i_sel_b,
  input  logic                        i_wr_acc,
  input  logic                        i_op_code,
  input  logic                        i_wr_ram,
  input  logic                        i_rd_ram,
  input  logic [NB_OPERAND-1:0]       i_operand,
  input  logic [LOG2_N_DATA_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0]          o_acc,
  output logic [NB_DATA-1:0]          o_dbg_data,
  output logic                        o_overflow
);

  logic [NB_DATA-1:0]          acc_q;
  logic                        ovf_q;
  logic [NB_DATA-1:0]          imm;
  logic [LOG2_N_DATA_ADDR-1:0] addr;
  logic [NB_DATA-1:0]          ram_q;
  logic [NB_DATA-1:0]          ram_rd;
  logic [NB_DATA-1:0]          mux_b;
  logic [NB_DATA-1:0]          alu;
  logic                        alu_ovf;
  logic [NB_DATA-1:0]          acc_nxt;
  logic                        ram_we;

  assign imm    = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};
  assign addr   = i_operand[LOG2_N_DATA_ADDR-1:0];
  assign ram_we = i_valid & i_wr_ram & ~i_reset;

  bip_data_ram u_ram (
    .i_clock  (i_clock),
    .wr_en    (ram_we),
    .wr_addr  (addr),
    .wr_data  (acc_q),
    .rd_addr  (addr),
    .rd_data  (ram_q),
    .dbg_addr (i_dbg_addr),
    .dbg_data (o_dbg_data)
  );

  // Single-cycle execute: operand select, ALU and accumulator source mux.
  always_comb begin
    ram_rd  = '0;
    mux_b   = '0;
    alu     = '0;
    alu_ovf = 1'b0;
    acc_nxt = acc_q;

    if (i_rd_ram) ram_rd = ram_q;
    mux_b = i_sel_b ? imm : ram_rd;

    if (i_op_code == OP_ADD) alu = acc_q + mux_b;
    else                     alu = acc_q - mux_b;
    alu_ovf = signed_ovf(i_op_code == OP_ADD, acc_q[NB_DATA-1],
                         mux_b[NB_DATA-1], alu[NB_DATA-1]);

    case (sel_a_e'(i_sel_a))
      SEL_A_RAM:  acc_nxt = ram_rd;
      SEL_A_IMM:  acc_nxt = imm;
      SEL_A_ALU:  acc_nxt = alu;
      SEL_A_HOLD: acc_nxt = acc_q;
      default:    acc_nxt = acc_q;
    endcase
  end

  // Overflow is sticky; only reset clears it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (i_valid && i_wr_acc) begin
      acc_q <= acc_nxt;
      if ((i_sel_a == SEL_A_ALU) && alu_ovf) ovf_q <= 1'b1;
    end
  end

  assign o_acc      = acc_q;
  assign o_overflow = ovf_q;

endmodule
